icache_loader: RTL and testbench

ICACHE_LOADER -- requirements
Module: icache_loader

---
 rtl/icache_loader_pkg.sv | 22 ++
 rtl/icache_loader_timeout.sv | 30 +++
 rtl/icache_loader.sv | 144 ++++++++++++++
 tb/tb_icache_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_loader_pkg.sv
// Shared types and constants for the instruction-cache loader: FSM states,
// frame sync byte, default frame limits and the count-field validity rule.
package icache_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_CHECK = 3'd4
    } state_e;

    localparam logic [7:0] SYNC_BYTE              = 8'hA5;
    localparam int         DEFAULT_MAX_INSTR      = 128;
    localparam int         DEFAULT_TIMEOUT_CYCLES = 1_000_000;

    // A count field is usable when it names at least one and at most max_n instructions.
    function automatic logic count_ok(input logic [7:0] n, input logic [8:0] max_n);
        return (n != 8'd0) && ({1'b0, n} <= max_n);
    endfunction

endpackage

// File: rtl/icache_loader_timeout.sv
// Inter-byte idle watchdog: counts cycles without a received byte while a
// frame is open and flags expiry on the TIMEOUT_CYCLES-th idle cycle.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign expired = enable && !clear && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/icache_loader.sv
// Serial frame loader: parses sync/count/payload/checksum frames from a byte
// stream and writes 16-bit instructions into the instruction store.
module icache_loader
    import icache_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int MAX_INSTR      = DEFAULT_MAX_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        write_enable,
    output logic [7:0]  write_instruction_index,
    output logic [15:0] write_instruction,
    output logic        busy,
    output logic        program_valid,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output state_e      state_dbg
);

    // rx_valid is a one-cycle strobe with no back-pressure: every strobed byte
    // is consumed in the cycle it arrives, including the cycle a write is out.

    localparam logic [8:0] MAX_N = 9'(MAX_INSTR);

    state_e      state, state_next;
    logic [7:0]  count, count_d;
    logic [7:0]  index, index_d;
    logic [7:0]  checksum, checksum_d;
    logic [7:0]  low_byte, low_byte_d;
    logic [7:0]  wr_idx_d;
    logic [15:0] wr_data_d;
    logic        we_d, done_d, err_d, pv_d;
    logic        expired;

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (rx_valid),
        .enable (state != ST_IDLE),
        .expired(expired)
    );

    always_comb begin
        state_next = state;
        count_d    = count;
        index_d    = index;
        checksum_d = checksum;
        low_byte_d = low_byte;
        wr_idx_d   = write_instruction_index;
        wr_data_d  = write_instruction;
        we_d       = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        pv_d       = program_valid;

        if (state != ST_IDLE && expired) begin
            err_d      = 1'b1;
            state_next = ST_IDLE;
        end else if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_next = ST_COUNT;
                        pv_d       = 1'b0;
                        index_d    = 8'd0;
                        checksum_d = 8'd0;
                    end
                end
                ST_COUNT: begin
                    if (!count_ok(rx_byte, MAX_N)) begin
                        err_d      = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        count_d    = rx_byte;
                        state_next = ST_LOW;
                    end
                end
                ST_LOW: begin
                    low_byte_d = rx_byte;
                    checksum_d = checksum ^ rx_byte;
                    state_next = ST_HIGH;
                end
                ST_HIGH: begin
                    checksum_d = checksum ^ rx_byte;
                    we_d       = 1'b1;
                    wr_data_d  = {rx_byte, low_byte};
                    wr_idx_d   = index;
                    index_d    = index + 8'd1;
                    state_next = (index == count - 8'd1) ? ST_CHECK : ST_LOW;
                end
                ST_CHECK: begin
                    if (rx_byte == checksum) begin
                        pv_d   = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= ST_IDLE;
            count                   <= 8'd0;
            index                   <= 8'd0;
            checksum                <= 8'd0;
            low_byte                <= 8'd0;
            write_instruction_index <= 8'd0;
            write_instruction       <= 16'd0;
            write_enable            <= 1'b0;
            load_done               <= 1'b0;
            load_error              <= 1'b0;
            program_valid           <= 1'b0;
        end else begin
            state                   <= state_next;
            count                   <= count_d;
            index                   <= index_d;
            checksum                <= checksum_d;
            low_byte                <= low_byte_d;
            write_instruction_index <= wr_idx_d;
            write_instruction       <= wr_data_d;
            write_enable            <= we_d;
            load_done               <= done_d;
            load_error              <= err_d;
            program_valid           <= pv_d;
        end
    end

    // The core stays held while a frame is open or no verified program exists.
    assign busy      = (state != ST_IDLE);
    assign cpu_hold  = busy | ~program_valid;
    assign state_dbg = state;

endmodule

// File: tb/tb_icache_loader.sv
// Randomized frame-level bench for icache_loader with a byte-list reference model.
module tb_icache_loader;
    import icache_loader_pkg::*;

    localparam int TO = 16;
    localparam int MI = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        rx_valid = 1'b0;
    logic        write_enable;
    logic [7:0]  write_instruction_index;
    logic [15:0] write_instruction;
    logic        busy, program_valid, cpu_hold, load_done, load_error;
    state_e      state_dbg;

    always #5 clk = ~clk;

    icache_loader #(.TIMEOUT_CYCLES(TO), .MAX_INSTR(MI)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .rx_byte                (rx_byte),
        .rx_valid               (rx_valid),
        .write_enable           (write_enable),
        .write_instruction_index(write_instruction_index),
        .write_instruction      (write_instruction),
        .busy                   (busy),
        .program_valid          (program_valid),
        .cpu_hold               (cpu_hold),
        .load_done              (load_done),
        .load_error             (load_error),
        .state_dbg              (state_dbg)
    );

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic prev_we = 1'b0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_w;
    logic [7:0]  pay[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every observed write must be the next expected one.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_we <= 1'b0;
        end else begin
            if (write_enable) begin
                check("we_single_cycle", {31'd0, prev_we}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {8'd0, write_instruction_index, write_instruction}, 32'hFFFF_FFFF);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("write", {8'd0, write_instruction_index, write_instruction}, {8'd0, exp_w});
                end
                wr_cnt <= wr_cnt + 1;
            end
            if (load_done)  done_cnt <= done_cnt + 1;
            if (load_error) err_cnt  <= err_cnt + 1;
            prev_we <= write_enable;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: a frame with a legal count writes pay[2i+1]:pay[2i] to
    // index i for every i, and succeeds iff chk equals the XOR of the payload.
    task automatic model_frame(input logic [7:0] n, input logic [7:0] chk,
                               output bit n_ok, output bit exp_done);
        logic [7:0] x;
        x = 8'd0;
        n_ok = (int'(n) >= 1) && (int'(n) <= MI);
        exp_done = 1'b0;
        if (!n_ok) return;
        for (int i = 0; i < 2 * int'(n); i++) x = x ^ pay[i];
        for (int i = 0; i < int'(n); i++) exp_q.push_back({8'(i), pay[2*i+1], pay[2*i]});
        exp_done = (x == chk);
    endtask

    task automatic check_idle_outputs(input string tag, input bit exp_pv);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_pv"}, {31'd0, program_valid}, {31'd0, exp_pv});
        check({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_pv});
        check({tag, "_state"}, {29'd0, state_dbg}, {29'd0, ST_IDLE});
        check({tag, "_pending_writes"}, exp_q.size(), 0);
    endtask

    task automatic do_frame(input string tag, input logic [7:0] n, input logic [7:0] chk, input int max_gap);
        bit n_ok, exp_done;
        int d0, e0;
        logic [7:0] bytes[$];
        model_frame(n, chk, n_ok, exp_done);
        d0 = done_cnt;
        e0 = err_cnt;
        bytes = {SYNC_BYTE, n};
        if (n_ok) begin
            foreach (pay[i]) bytes.push_back(pay[i]);
            bytes.push_back(chk);
        end
        foreach (bytes[i])
            send_byte(bytes[i], (i == bytes.size() - 1) ? 0 : $urandom_range(0, max_gap));
        check({tag, "_done_now"}, {31'd0, load_done}, {31'd0, exp_done});
        check({tag, "_error_now"}, {31'd0, load_error}, {31'd0, !exp_done});
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_done_pulses"}, done_cnt - d0, exp_done ? 1 : 0);
        check({tag, "_error_pulses"}, err_cnt - e0, exp_done ? 0 : 1);
        check_idle_outputs(tag, exp_done);
    endtask

    // Sends sync, n and the first npay payload bytes of pay, then goes silent.
    task automatic timeout_case(input string tag, input logic [7:0] n, input int npay);
        int d0, e0, lat;
        d0 = done_cnt;
        e0 = err_cnt;
        lat = -1;
        for (int i = 0; i < npay / 2; i++) exp_q.push_back({8'(i), pay[2*i+1], pay[2*i]});
        send_byte(SYNC_BYTE, 0);
        send_byte(n, 0);
        for (int i = 0; i < npay; i++) send_byte(pay[i], 0);
        for (int c = 1; c <= TO + 8; c++) begin
            @(posedge clk);
            #1;
            if (load_error && lat < 0) lat = c;
        end
        check({tag, "_latency"}, lat, TO);
        check({tag, "_error_pulses"}, err_cnt - e0, 1);
        check({tag, "_done_pulses"}, done_cnt - d0, 0);
        check_idle_outputs(tag, 1'b0);
    endtask

    task automatic fill_random_payload(input int n);
        pay.delete();
        for (int i = 0; i < 2 * n; i++)
            pay.push_back(($urandom_range(0, 7) == 0) ? SYNC_BYTE : 8'($urandom_range(0, 255)));
    endtask

    initial begin
        int w0, e0, n;
        logic [7:0] x, chk, junk;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", {31'd0, write_enable}, 32'd0);
        check("rst_idx", {24'd0, write_instruction_index}, 32'd0);
        check("rst_instr", {16'd0, write_instruction}, 32'd0);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_error", {31'd0, load_error}, 32'd0);
        check_idle_outputs("rst", 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        pay = {8'h34, 8'h12, 8'h78, 8'h56};
        do_frame("good2", 8'h02, 8'h08, 2);
        do_frame("badchk", 8'h02, 8'h09, 0);
        pay.delete();
        do_frame("count0", 8'h00, 8'h00, 0);
        do_frame("count81", 8'h81, 8'h00, 0);
        pay = {8'hA5, 8'hA5, 8'hA5, 8'h00};
        do_frame("midsync", 8'h02, 8'hA5, 1);
        pay = {8'hEF, 8'hBE};
        do_frame("one", 8'h01, 8'h51, 3);

        pay = {8'h34};
        timeout_case("to_low", 8'h01, 1);
        pay = {8'h34, 8'h12, 8'h78, 8'h56};
        timeout_case("to_partial", 8'h02, 3);

        // Non-sync bytes in idle must be ignored entirely.
        e0 = err_cnt;
        w0 = wr_cnt;
        for (int i = 0; i < 6; i++) begin
            junk = 8'($urandom_range(0, 255));
            if (junk == SYNC_BYTE) junk = 8'h00;
            send_byte(junk, $urandom_range(0, 2));
        end
        check("junk_errors", err_cnt - e0, 0);
        check("junk_writes", wr_cnt - w0, 0);
        check_idle_outputs("junk", 1'b0);

        fill_random_payload(128);
        x = 8'd0;
        foreach (pay[i]) x = x ^ pay[i];
        w0 = wr_cnt;
        do_frame("full128", 8'h80, x, 0);
        check("full128_writes", wr_cnt - w0, 128);

        for (int f = 0; f < 10; f++) begin
            n = $urandom_range(1, 10);
            fill_random_payload(n);
            x = 8'd0;
            foreach (pay[i]) x = x ^ pay[i];
            chk = ($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x;
            if ($urandom_range(0, 7) == 0) begin
                pay.delete();
                do_frame("rand_badn", ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(129, 255)), chk, 3);
            end else begin
                do_frame("rand", 8'(n), chk, 4);
            end
        end

        // Reset after the third payload byte: only index 0 may have been written.
        pay = {8'h34, 8'h12, 8'h78, 8'h56};
        exp_q.push_back({8'h00, 16'h1234});
        send_byte(SYNC_BYTE, 0);
        send_byte(8'h02, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        send_byte(8'h78, 0);
        rst_n = 1'b0;
        #1;
        w0 = wr_cnt;
        e0 = err_cnt;
        check("midrst_we", {31'd0, write_enable}, 32'd0);
        check("midrst_idx", {24'd0, write_instruction_index}, 32'd0);
        check("midrst_instr", {16'd0, write_instruction}, 32'd0);
        check("midrst_done", {31'd0, load_done}, 32'd0);
        check("midrst_error", {31'd0, load_error}, 32'd0);
        check_idle_outputs("midrst", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (TO + 4) begin
            @(posedge clk);
            #1;
        end
        check("midrst_no_writes", wr_cnt - w0, 0);
        check("midrst_no_errors", err_cnt - e0, 0);
        check_idle_outputs("postrst", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
